cvm300_pixel_packer: RTL and testbench

Capture stage between the CVM300 parallel pixel bus and the image FIFO write port; runs entirely in the camera output clock domain (CVM300_CLK_OUT).
Qualifies pixels with Line_valid/Data_valid, keeps the upper 8 of 10 bits, and packs four pixels per 32-bit FIFO word.
Tracks pixels per line and lines per frame, pulses frame_done at frame end, and reports overflow and short/long-line errors.
Captures exactly one frame per arm pulse; the arm pulse follows each frame request.

---
 rtl/cvm300_pixel_packer_pkg.sv | 20 ++
 rtl/cvm300_pixel_packer_pixel_word_packer.sv | 76 +++++++
 rtl/cvm300_pixel_packer.sv | 121 ++++++++++++
 tb/tb_cvm300_pixel_packer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvm300_pixel_packer_pkg.sv
// Shared definitions for the CVM300 capture path: state encoding, pixel byte
// select and the sensor's default frame geometry.
package cvm300_pixel_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int PIX_IN_W = 10;
    localparam int PIX_MSB  = 9;
    localparam int PIX_LSB  = 2;
    localparam int BYTE_W   = PIX_MSB - PIX_LSB + 1;

    localparam int DEF_LINE_PIXELS = 648;
    localparam int DEF_FRAME_LINES = 488;

endpackage

// File: rtl/cvm300_pixel_packer_pixel_word_packer.sv
// Packs qualified pixel bytes four to a 32-bit word, first byte in the MSBs,
// and zero-pads a partial word when the line ends.
module pixel_word_packer
    import cvm300_pixel_packer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              pixel_valid,
    input  logic [BYTE_W-1:0] pixel,
    input  logic              flush,
    input  logic              fifo_full,
    output logic              wr_en,
    output logic [31:0]       din,
    output logic              drop
);

    logic [1:0]  slot_p0;
    logic [23:0] hold_p0;
    logic [31:0] word_p1;
    logic        vld_p1;

    function automatic logic [31:0] pad_word(input logic [23:0] hold, input logic [1:0] slot);
        logic [31:0] w;
        case (slot)
            2'd1:    w = {hold[23:16], 24'h0};
            2'd2:    w = {hold[23:8], 16'h0};
            2'd3:    w = {hold, 8'h0};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // stage 0: slot counter and holding bytes
    always_ff @(posedge clk) begin
        if (pixel_valid) begin
            case (slot_p0)
                2'd0:    hold_p0[23:16] <= pixel;
                2'd1:    hold_p0[15:8]  <= pixel;
                2'd2:    hold_p0[7:0]   <= pixel;
                default: hold_p0        <= hold_p0;
            endcase
        end
    end

    // stage 1: completed word waiting for its write cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_p0 <= 2'd0;
            vld_p1  <= 1'b0;
            word_p1 <= 32'h0;
        end else if (clear) begin
            slot_p0 <= 2'd0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (pixel_valid) begin
                if (slot_p0 == 2'd3) begin
                    word_p1 <= {hold_p0, pixel};
                    vld_p1  <= 1'b1;
                end
                slot_p0 <= slot_p0 + 2'd1;
            end else if (flush && slot_p0 != 2'd0) begin
                word_p1 <= pad_word(hold_p0, slot_p0);
                vld_p1  <= 1'b1;
                slot_p0 <= 2'd0;
            end
        end
    end

    // fifo_full is judged in the write cycle itself, so the strobe is gated live
    assign wr_en = vld_p1 && !fifo_full;
    assign drop  = vld_p1 && fifo_full;
    assign din   = word_p1;

endmodule

// File: rtl/cvm300_pixel_packer.sv
// CVM300 pixel bus capture: arms on request, captures one frame from the next
// line start, tracks line geometry and flags overflow / bad line lengths.
module cvm300_pixel_packer
    import cvm300_pixel_packer_pkg::*;
#(
    parameter int LINE_PIXELS = DEF_LINE_PIXELS,
    parameter int FRAME_LINES = DEF_FRAME_LINES,
    parameter int CNT_W       = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic                abort,
    input  logic [PIX_IN_W-1:0] pix_data,
    input  logic                line_valid,
    input  logic                data_valid,
    input  logic                fifo_full,
    output logic                fifo_wr_en,
    output logic [31:0]         fifo_din,
    output logic                frame_done,
    output logic                busy,
    output logic                overflow,
    output logic                line_err,
    output logic [CNT_W-1:0]    line_count,
    output logic [7:0]          state
);

    localparam logic [CNT_W-1:0] LINE_PIX_C = CNT_W'(LINE_PIXELS);
    localparam logic [CNT_W-1:0] FRAME_LN_C = CNT_W'(FRAME_LINES);

    state_t           state_q, state_d;
    logic             lv_q;
    logic [CNT_W-1:0] pix_q, line_q, line_nxt;
    logic             ovf_q, lerr_q;
    logic             rise, fall, cap_pix, line_end, drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [BYTE_W-1:0] pix_byte(input logic [PIX_IN_W-1:0] raw);
        return raw[PIX_MSB:PIX_LSB];
    endfunction

    assign rise     = line_valid && !lv_q;
    assign fall     = !line_valid && lv_q;
    // the rising-edge cycle of the first line already carries pixel 0
    assign cap_pix  = line_valid && data_valid && !abort &&
                      (state_q == ST_CAPTURE || (state_q == ST_ARMED && rise));
    assign line_end = fall && !abort && state_q == ST_CAPTURE;
    assign line_nxt = line_q + 1'b1;

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (arm) state_d = ST_ARMED;
                ST_ARMED:   if (rise) state_d = ST_CAPTURE;
                ST_CAPTURE: if (line_end && line_nxt == FRAME_LN_C) state_d = ST_DONE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lv_q    <= line_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q  <= '0;
            line_q <= '0;
            ovf_q  <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && arm && !abort) begin
                pix_q  <= '0;
                line_q <= '0;
                ovf_q  <= 1'b0;
                lerr_q <= 1'b0;
            end
            if (cap_pix) pix_q <= sat_inc(pix_q);
            if (line_end) begin
                pix_q  <= '0;
                line_q <= line_nxt;
                // a padded partial line can never match a multiple-of-4 length
                if (pix_q != LINE_PIX_C) lerr_q <= 1'b1;
            end
            if (drop) ovf_q <= 1'b1;
        end
    end

    pixel_word_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear       (abort),
        .pixel_valid (cap_pix),
        .pixel       (pix_byte(pix_data)),
        .flush       (line_end),
        .fifo_full   (fifo_full),
        .wr_en       (fifo_wr_en),
        .din         (fifo_din),
        .drop        (drop)
    );

    assign frame_done = (state_q == ST_DONE);
    assign busy       = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign overflow   = ovf_q;
    assign line_err   = lerr_q;
    assign line_count = line_q;
    assign state      = {6'd0, state_q};

endmodule

// File: tb/tb_cvm300_pixel_packer.sv
// Randomized bench for cvm300_pixel_packer against a frame-level reference model.
module tb_cvm300_pixel_packer;

    localparam int LP = 8;
    localparam int FL = 2;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst, arm, abort, line_valid, data_valid, fifo_full;
    logic [9:0]    pix_data;
    logic          fifo_wr_en, frame_done, busy, overflow, line_err;
    logic [31:0]   fifo_din;
    logic [CW-1:0] line_count;
    logic [7:0]    state;

    cvm300_pixel_packer #(.LINE_PIXELS(LP), .FRAME_LINES(FL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .pix_data(pix_data),
        .line_valid(line_valid), .data_valid(data_valid), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .frame_done(frame_done),
        .busy(busy), .overflow(overflow), .line_err(line_err),
        .line_count(line_count), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       lv;
        logic       dv;
        logic [9:0] d;
        logic       full;
        logic       ab;
    } cyc_t;

    cyc_t        plan[$];
    logic [7:0]  lb[$];
    logic [7:0]  m_cur[$];
    logic [31:0] exp_w[$], got_w[$];
    int          exp_c[$], got_c[$];
    logic [7:0]  st_log[$];
    int          exp_done, done_n, done_c, exp_lines;
    logic        exp_ovf, exp_lerr;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic add_cyc(input logic lv, input logic dv, input logic [9:0] d);
        cyc_t c;
        c.lv = lv; c.dv = dv; c.d = d; c.full = 1'b0; c.ab = 1'b0;
        plan.push_back(c);
    endtask

    task automatic add_idle(input int n);
        for (int k = 0; k < n; k++) add_cyc(1'b0, 1'($urandom), 10'($urandom));
    endtask

    // mode 0: random gaps at pct; mode 1: exactly one gap before every pixel
    task automatic add_line(input int mode, input int pct);
        for (int k = 0; k < lb.size(); k++) begin
            if (mode == 1) add_cyc(1'b1, 1'b0, 10'($urandom));
            else while (int'($urandom_range(99)) < pct) add_cyc(1'b1, 1'b0, 10'($urandom));
            add_cyc(1'b1, 1'b1, {lb[k], 2'($urandom)});
        end
        add_cyc(1'b0, 1'($urandom), 10'($urandom));
    endtask

    task automatic rand_bytes(input int n);
        lb.delete();
        for (int k = 0; k < n; k++) lb.push_back(8'($urandom));
    endtask

    task automatic emit(input int c);
        logic [31:0] w = 32'h0;
        for (int k = 0; k < 4; k++) w = (w << 8) | ((k < m_cur.size()) ? 32'(m_cur[k]) : 32'h0);
        m_cur.delete();
        if (c < plan.size() && plan[c].full) exp_ovf = 1'b1;
        else begin
            exp_w.push_back(w);
            exp_c.push_back(c);
        end
    endtask

    // Frame-level model: capture starts at the first line start after arm,
    // words go out one cycle after their 4th byte or after the line end.
    task automatic model(input logic arm_lv);
        bit   armed = 1'b1, cap = 1'b0, fin = 1'b0;
        int   npix = 0;
        logic prev;
        exp_w.delete(); exp_c.delete(); m_cur.delete();
        exp_done = -1; exp_ovf = 1'b0; exp_lerr = 1'b0; exp_lines = 0;
        for (int i = 0; i < plan.size(); i++) begin
            prev = (i == 0) ? arm_lv : plan[i-1].lv;
            if (fin) continue;
            if (plan[i].ab) begin
                fin = 1'b1;
                continue;
            end
            if (armed && plan[i].lv && !prev) begin
                armed = 1'b0;
                cap = 1'b1;
            end
            if (cap && plan[i].lv && plan[i].dv) begin
                m_cur.push_back(plan[i].d[9:2]);
                npix++;
                if (m_cur.size() == 4) emit(i + 1);
            end
            if (cap && !plan[i].lv && prev) begin
                if (m_cur.size() > 0) emit(i + 1);
                if (npix != LP) exp_lerr = 1'b1;
                npix = 0;
                exp_lines++;
                if (exp_lines == FL) begin
                    fin = 1'b1;
                    exp_done = i + 1;
                end
            end
        end
    endtask

    task automatic drive_idle();
        arm = 1'b0; abort = 1'b0; line_valid = 1'b0; fifo_full = 1'b0;
        data_valid = 1'($urandom); pix_data = 10'($urandom);
    endtask

    task automatic run(input logic arm_lv);
        got_w.delete(); got_c.delete(); st_log.delete();
        done_n = 0; done_c = -1;
        @(posedge clk); #1;
        drive_idle();
        arm = 1'b1; line_valid = arm_lv;
        for (int i = 0; i < plan.size(); i++) begin
            @(posedge clk); #1;
            arm = 1'b0;
            line_valid = plan[i].lv; data_valid = plan[i].dv; pix_data = plan[i].d;
            fifo_full = plan[i].full; abort = plan[i].ab;
            @(negedge clk);
            if (fifo_wr_en) begin
                got_w.push_back(fifo_din);
                got_c.push_back(i);
            end
            if (frame_done) begin
                done_n++;
                done_c = i;
            end
            st_log.push_back(state);
        end
        @(posedge clk); #1;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_frame(input string nm);
        int n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
        chk({nm, "_nwr"}, got_w.size(), exp_w.size());
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_w%0d", nm, k), got_w[k], exp_w[k]);
            chk($sformatf("%s_c%0d", nm, k), got_c[k], exp_c[k]);
        end
        chk({nm, "_done_n"}, done_n, (exp_done < 0) ? 0 : 1);
        if (exp_done >= 0) chk({nm, "_done_c"}, done_c, exp_done);
        chk({nm, "_ovf"}, overflow, exp_ovf);
        chk({nm, "_lerr"}, line_err, exp_lerr);
        chk({nm, "_lines"}, line_count, exp_lines);
        chk({nm, "_state"}, state, 0);
        chk({nm, "_busy"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr", fifo_wr_en, 0);
        chk("rst_din", fifo_din, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {overflow, line_err}, 0);
        chk("rst_lines", line_count, 0);
        chk("rst_state", state, 0);
        @(posedge clk); #1 rst = 1'b0;

        // two clean 8-pixel lines, bytes 01..08
        plan.delete(); add_idle(3);
        lb.delete();
        for (int k = 1; k <= 8; k++) lb.push_back(8'(k));
        add_line(0, 0); add_idle(3); add_line(0, 0); add_idle(4);
        model(1'b0); run(1'b0); check_frame("t1");
        chk("t1_w0_lit", (got_w.size() > 0) ? got_w[0] : 32'hx, 32'h01020304);
        chk("t1_w1_lit", (got_w.size() > 1) ? got_w[1] : 32'hx, 32'h05060708);

        // line_valid already high at arm: the tail of that line is skipped
        plan.delete(); rand_bytes(3); add_line(0, 0); add_idle(2);
        rand_bytes(8); add_line(0, 20); add_idle(2);
        rand_bytes(8); add_line(0, 20); add_idle(4);
        model(1'b1); run(1'b1); check_frame("t2");
        chk("t2_nwr4", got_w.size(), 4);

        // short line: AA..FF gives one full and one padded word
        plan.delete(); add_idle(2);
        lb.delete();
        for (int k = 0; k < 6; k++) lb.push_back(8'(8'hAA + 17 * k));
        add_line(0, 0); add_idle(2); rand_bytes(8); add_line(0, 0); add_idle(4);
        model(1'b0); run(1'b0); check_frame("t3");
        chk("t3_w0_lit", (got_w.size() > 0) ? got_w[0] : 32'hx, 32'hAABBCCDD);
        chk("t3_w1_lit", (got_w.size() > 1) ? got_w[1] : 32'hx, 32'hEEFF0000);
        chk("t3_lerr1", line_err, 1);

        // fifo_full during the second word's write cycle
        plan.delete(); add_idle(2); rand_bytes(8); add_line(0, 0); add_idle(2);
        rand_bytes(8); add_line(0, 0); add_idle(4);
        model(1'b0);
        if (exp_c.size() > 1) plan[exp_c[1]].full = 1'b1;
        model(1'b0); run(1'b0); check_frame("t4");
        chk("t4_nwr3", got_w.size(), 3);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t4_ovf_sticky", overflow, 1);

        // abort after the 5th pixel of the first line
        plan.delete(); add_idle(2); rand_bytes(8); add_line(0, 0);
        plan[2 + 5].ab = 1'b1;
        add_idle(2); rand_bytes(8); add_line(0, 0); add_idle(4);
        model(1'b0); run(1'b0); check_frame("t5");
        chk("t5_st_after", (st_log.size() > 8) ? 32'(st_log[8]) : 32'hx, 0);
        chk("t5_nwr1", got_w.size(), 1);

        plan.delete(); add_idle(2); rand_bytes(8); add_line(0, 10); add_idle(2);
        rand_bytes(8); add_line(0, 10); add_idle(4);
        model(1'b0); run(1'b0); check_frame("t5b");

        // data_valid alternating inside the line
        plan.delete(); add_idle(2); rand_bytes(8); add_line(1, 0); add_idle(2);
        rand_bytes(8); add_line(1, 0); add_idle(4);
        model(1'b0); run(1'b0); check_frame("t6");

        for (int f = 0; f < 8; f++) begin
            logic alv = 1'($urandom);
            plan.delete();
            if (alv) begin
                rand_bytes(int'($urandom_range(6)));
                add_line(0, 30);
            end
            add_idle(int'($urandom_range(1, 3)));
            for (int l = 0; l < FL; l++) begin
                rand_bytes((f % 2 == 0) ? LP : int'($urandom_range(1, 12)));
                add_line(0, 30);
                add_idle(int'($urandom_range(1, 3)));
            end
            add_idle(3);
            for (int i = 0; i < plan.size(); i++) plan[i].full = ($urandom_range(9) == 0);
            model(alv); run(alv);
            check_frame($sformatf("rnd%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
